// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST signature controller.
package bist_pkg;

  localparam int SIG_WIDTH = 16;
  localparam logic [SIG_WIDTH-1:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CAPTURE,
    DONE
  } bist_state_t;

endpackage

// File: rtl/bist_delay_line.sv
// 1-bit enable delay line; DEPTH 0 is a plain pass-through of d.
module bist_delay_line #(
  parameter int DEPTH = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // One spare stage exists at DEPTH 0 so the port list stays identical.
  localparam int SR_W = (DEPTH == 0) ? 1 : DEPTH;

  logic [SR_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | SR_W'(d);
    end
  end

  assign q = (DEPTH == 0) ? d : sr[SR_W-1];

endmodule

// File: rtl/bist_sig_ctrl.sv
// Sequences one MISR compaction run and compares the captured signature to golden.
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | MISR cleared to seed
// RUN     | pattern source enabled, PATTERN_COUNT cycles
// DRAIN   | enable pipeline empties, RESP_LATENCY cycles
// CAPTURE | signature and pass loaded
// DONE    | done pulse
module bist_sig_ctrl
  import bist_pkg::*;
#(
  parameter int PATTERN_COUNT = 1024,
  parameter int RESP_LATENCY  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] golden,
  input  logic [SIG_WIDTH-1:0] misr_out,
  output logic                 misr_reset,
  output logic                 misr_enable,
  output logic                 pat_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int CNT_W = $clog2(PATTERN_COUNT + 1);
  localparam int DRN_W = 4;

  bist_state_t          state;
  bist_state_t          state_nx;
  logic [CNT_W-1:0]     pat_cnt;
  logic [DRN_W-1:0]     drn_cnt;
  logic [SIG_WIDTH-1:0] golden_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN: begin
        if (pat_cnt == CNT_W'(1)) state_nx = (RESP_LATENCY == 0) ? CAPTURE : DRAIN;
      end
      DRAIN:   if (drn_cnt == DRN_W'(1)) state_nx = CAPTURE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_cnt   <= '0;
      drn_cnt   <= '0;
      golden_q  <= '0;
      signature <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            golden_q <= golden;
            pass     <= 1'b0;
          end
        end
        CLEAR: pat_cnt <= CNT_W'(PATTERN_COUNT);
        RUN: begin
          pat_cnt <= pat_cnt - CNT_W'(1);
          if (pat_cnt == CNT_W'(1)) drn_cnt <= DRN_W'(RESP_LATENCY);
        end
        DRAIN: drn_cnt <= drn_cnt - DRN_W'(1);
        CAPTURE: begin
          signature <= misr_out;
          pass      <= (misr_out == golden_q);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misr_reset <= 1'b1;
      pat_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      misr_reset <= (state_nx == CLEAR);
      pat_enable <= (state_nx == RUN);
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == DONE);
    end
  end

  bist_delay_line #(
    .DEPTH(RESP_LATENCY)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    (pat_enable),
    .q    (misr_enable)
  );

endmodule
